// File: rtl/cache_sa_wb_ctrl.sv
// ---------------------------------------------------------------------------
// cache_sa_wb_ctrl
// N-way set-associative, write-back, write-allocate cache controller with
// true-LRU replacement (per-way ages, 0 = most recently used).
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   cpu_req_valid/ready         CPU request handshake (ready only in IDLE)
//   cpu_req_we/addr/wdata       store flag, byte address, store data
//   cpu_resp_valid/hit/rdata    one-cycle response pulse, original-lookup hit,
//                               load data (0 for stores)
//   flush_req / flush_done      write back every dirty line / completion pulse
//   mem_req/we/addr/wdata       block request to memory (we=1 write-back)
//   mem_rdata / mem_ack         refill block / one-cycle completion
// ---------------------------------------------------------------------------
module cache_sa_wb_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int WAYS   = 2,
    parameter int SETS   = 2,
    parameter int WORDS  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cpu_req_valid,
    output logic                      cpu_req_ready,
    input  logic                      cpu_req_we,
    input  logic [ADDR_W-1:0]         cpu_req_addr,
    input  logic [DATA_W-1:0]         cpu_req_wdata,
    output logic                      cpu_resp_valid,
    output logic                      cpu_resp_hit,
    output logic [DATA_W-1:0]         cpu_resp_rdata,
    input  logic                      flush_req,
    output logic                      flush_done,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [WORDS*DATA_W-1:0]   mem_wdata,
    input  logic [WORDS*DATA_W-1:0]   mem_rdata,
    input  logic                      mem_ack
);
    localparam int OFF_B  = $clog2(WORDS);
    localparam int IDX_B  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - 2 - OFF_B - IDX_B;
    // Zero-width fields are carried as one always-zero bit.
    localparam int WORD_W = (OFF_B > 0) ? OFF_B : 1;
    localparam int SET_W  = (IDX_B > 0) ? IDX_B : 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BLK_W  = WORDS * DATA_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESP,
        S_FLUSH_SCAN, S_FLUSH_WB, S_FLUSH_DONE
    } state_t;

    state_t              state_q;
    logic                req_we_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [DATA_W-1:0]   req_wdata_q;
    logic                hit_flag_q;
    logic [WAY_W-1:0]    victim_q;
    logic [SET_W-1:0]    fset_q;
    logic [WAY_W-1:0]    fway_q;
    logic                valid_q [SETS][WAYS];
    logic                dirty_q [SETS][WAYS];
    logic [WAY_W-1:0]    age_q   [SETS][WAYS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [DATA_W-1:0]   data_q  [SETS][WAYS][WORDS];

    logic                mem_req_q, mem_we_q, resp_valid_q, resp_hit_q, flush_done_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [BLK_W-1:0]    mem_wdata_q;
    logic [DATA_W-1:0]   resp_rdata_q;

    logic [WORD_W-1:0]   req_word_s;
    logic [SET_W-1:0]    req_set_s;
    logic [TAG_W-1:0]    req_tag_s;
    logic                hit_s, inv_s, last_line_s;
    logic [WAY_W-1:0]    hit_way_s, inv_way_s, lru_way_s, victim_s;
    logic [BLK_W-1:0]    victim_blk_s, flush_blk_s;

    // Block-aligned byte address of a (tag, set) pair.
    function automatic logic [ADDR_W-1:0] blk_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [SET_W-1:0] set);
        return (ADDR_W'(tag) << (2 + OFF_B + IDX_B)) | (ADDR_W'(set) << (2 + OFF_B));
    endfunction

    assign cpu_req_ready  = (state_q == S_IDLE) && !flush_req;
    assign cpu_resp_valid = resp_valid_q;
    assign cpu_resp_hit   = resp_hit_q;
    assign cpu_resp_rdata = resp_rdata_q;
    assign flush_done     = flush_done_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;

    // Address split of the latched request; masks keep zero-width fields at 0.
    assign req_word_s  = WORD_W'((req_addr_q >> 2) & ADDR_W'(WORDS - 1));
    assign req_set_s   = SET_W'((req_addr_q >> (2 + OFF_B)) & ADDR_W'(SETS - 1));
    assign req_tag_s   = TAG_W'(req_addr_q >> (2 + OFF_B + IDX_B));
    assign last_line_s = (fset_q == SET_W'(SETS - 1)) && (fway_q == WAY_W'(WAYS - 1));
    assign victim_s    = inv_s ? inv_way_s : lru_way_s;

    // Tag match, lowest invalid way and oldest way of the request set; descending scan lets the lowest index win.
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = {WAY_W{1'b0}};
        inv_s     = 1'b0;
        inv_way_s = {WAY_W{1'b0}};
        lru_way_s = {WAY_W{1'b0}};
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_s     = hit_s | (valid_q[req_set_s][w] && (tag_q[req_set_s][w] == req_tag_s));
            hit_way_s = (valid_q[req_set_s][w] && (tag_q[req_set_s][w] == req_tag_s)) ? WAY_W'(w) : hit_way_s;
            inv_s     = inv_s | !valid_q[req_set_s][w];
            inv_way_s = !valid_q[req_set_s][w] ? WAY_W'(w) : inv_way_s;
            lru_way_s = (age_q[req_set_s][w] == WAY_W'(WAYS - 1)) ? WAY_W'(w) : lru_way_s;
        end
    end

    // Flatten the victim line and the line under the flush cursor into memory blocks.
    always_comb begin
        victim_blk_s = {BLK_W{1'b0}};
        flush_blk_s  = {BLK_W{1'b0}};
        for (int i = 0; i < WORDS; i++) begin
            victim_blk_s[i*DATA_W +: DATA_W] = data_q[req_set_s][victim_s][i];
            flush_blk_s[i*DATA_W +: DATA_W]  = data_q[fset_q][fway_q][i];
        end
    end

    // Data and tag arrays: refill install and store-hit write; no reset needed.
    always_ff @(posedge clk) begin
        if (state_q == S_REFILL && mem_ack) begin
            tag_q[req_set_s][victim_q] <= req_tag_s;
            for (int i = 0; i < WORDS; i++) begin
                data_q[req_set_s][victim_q][i] <= mem_rdata[i*DATA_W +: DATA_W];
            end
        end else if (state_q == S_LOOKUP && hit_s && req_we_q) begin
            data_q[req_set_s][hit_way_s][req_word_s] <= req_wdata_q;
        end
    end

    // Controller FSM with line state, LRU ages and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_we_q     <= 1'b0;
            req_addr_q   <= {ADDR_W{1'b0}};
            req_wdata_q  <= {DATA_W{1'b0}};
            hit_flag_q   <= 1'b0;
            victim_q     <= {WAY_W{1'b0}};
            fset_q       <= {SET_W{1'b0}};
            fway_q       <= {WAY_W{1'b0}};
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {BLK_W{1'b0}};
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_rdata_q <= {DATA_W{1'b0}};
            flush_done_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (flush_req) begin
                        fset_q  <= {SET_W{1'b0}};
                        fway_q  <= {WAY_W{1'b0}};
                        state_q <= S_FLUSH_SCAN;
                    end else if (cpu_req_valid) begin
                        req_we_q    <= cpu_req_we;
                        req_addr_q  <= cpu_req_addr;
                        req_wdata_q <= cpu_req_wdata;
                        hit_flag_q  <= 1'b1;
                        state_q     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit_s) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == hit_way_s) begin
                                age_q[req_set_s][w] <= {WAY_W{1'b0}};
                            end else if (age_q[req_set_s][w] < age_q[req_set_s][hit_way_s]) begin
                                age_q[req_set_s][w] <= age_q[req_set_s][w] + WAY_W'(1);
                            end
                        end
                        if (req_we_q) begin
                            dirty_q[req_set_s][hit_way_s] <= 1'b1;
                            resp_rdata_q <= {DATA_W{1'b0}};
                        end else begin
                            resp_rdata_q <= data_q[req_set_s][hit_way_s][req_word_s];
                        end
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= hit_flag_q;
                        state_q      <= S_RESP;
                    end else begin
                        hit_flag_q <= 1'b0;
                        victim_q   <= victim_s;
                        mem_req_q  <= 1'b1;
                        if (valid_q[req_set_s][victim_s] && dirty_q[req_set_s][victim_s]) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= blk_addr(tag_q[req_set_s][victim_s], req_set_s);
                            mem_wdata_q <= victim_blk_s;
                            state_q     <= S_WRITEBACK;
                        end else begin
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= blk_addr(req_tag_s, req_set_s);
                            state_q    <= S_REFILL;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack) begin
                        dirty_q[req_set_s][victim_q] <= 1'b0;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= blk_addr(req_tag_s, req_set_s);
                        state_q    <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    // Return to LOOKUP so the now-present line is handled as an ordinary hit.
                    if (mem_ack) begin
                        valid_q[req_set_s][victim_q] <= 1'b1;
                        dirty_q[req_set_s][victim_q] <= 1'b0;
                        mem_req_q <= 1'b0;
                        state_q   <= S_LOOKUP;
                    end
                end
                S_RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_hit_q   <= 1'b0;
                    resp_rdata_q <= {DATA_W{1'b0}};
                    state_q      <= S_IDLE;
                end
                S_FLUSH_SCAN: begin
                    if (valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q]) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= blk_addr(tag_q[fset_q][fway_q], fset_q);
                        mem_wdata_q <= flush_blk_s;
                        state_q     <= S_FLUSH_WB;
                    end else if (last_line_s) begin
                        flush_done_q <= 1'b1;
                        state_q      <= S_FLUSH_DONE;
                    end else if (fway_q == WAY_W'(WAYS - 1)) begin
                        fway_q <= {WAY_W{1'b0}};
                        fset_q <= fset_q + SET_W'(1);
                    end else begin
                        fway_q <= fway_q + WAY_W'(1);
                    end
                end
                S_FLUSH_WB: begin
                    if (mem_ack) begin
                        dirty_q[fset_q][fway_q] <= 1'b0;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (last_line_s) begin
                            flush_done_q <= 1'b1;
                            state_q      <= S_FLUSH_DONE;
                        end else if (fway_q == WAY_W'(WAYS - 1)) begin
                            fway_q  <= {WAY_W{1'b0}};
                            fset_q  <= fset_q + SET_W'(1);
                            state_q <= S_FLUSH_SCAN;
                        end else begin
                            fway_q  <= fway_q + WAY_W'(1);
                            state_q <= S_FLUSH_SCAN;
                        end
                    end
                end
                S_FLUSH_DONE: begin
                    flush_done_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_sa_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_sa_wb_ctrl
// Randomised bench for cache_sa_wb_ctrl (default geometry). A reference model
// keeps the cache as plain arrays with last-use timestamps for LRU and a word
// array as main memory; every access predicts hit/miss, memory transactions,
// response data and latency, and a responder acks with random delays.
// ---------------------------------------------------------------------------
module tb_cache_sa_wb_ctrl;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int WAYS   = 2;
    localparam int SETS   = 2;
    localparam int WORDS  = 4;
    localparam int OFF_B  = 2;
    localparam int IDX_B  = 1;
    localparam int BLK_W  = WORDS * DATA_W;
    localparam int MEM_WORDS = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [DATA_W-1:0] cpu_req_wdata;
    logic              cpu_resp_valid, cpu_resp_hit;
    logic [DATA_W-1:0] cpu_resp_rdata;
    logic              flush_req, flush_done;
    logic              mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [BLK_W-1:0]  mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    cache_sa_wb_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_hit(cpu_resp_hit), .cpu_resp_rdata(cpu_resp_rdata),
        .flush_req(flush_req), .flush_done(flush_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit                m_v    [SETS][WAYS];
    bit                m_d    [SETS][WAYS];
    int                m_tag  [SETS][WAYS];
    int                m_used [SETS][WAYS];
    logic [DATA_W-1:0] m_data [SETS][WAYS][WORDS];
    logic [DATA_W-1:0] mem_m  [MEM_WORDS];
    int                now_t = 0;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BLK_W-1:0]  wd;
    } txn_t;
    txn_t exp_q[$];

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_v[s][w] = 1'b0;
                m_d[s][w] = 1'b0;
                m_used[s][w] = -w;   // way 0 most recent, highest way least recent
            end
        end
        now_t = 0;
        exp_q.delete();
    endfunction

    function automatic logic [BLK_W-1:0] mem_blk(input int baddr);
        logic [BLK_W-1:0] b;
        for (int i = 0; i < WORDS; i++) b[i*DATA_W +: DATA_W] = mem_m[baddr/4 + i];
        return b;
    endfunction

    // Queue a write-back of a model line and apply it to model memory.
    function automatic void model_writeback(input int s, input int w);
        txn_t t;
        int   a;
        a = (m_tag[s][w] << (2 + OFF_B + IDX_B)) + (s << (2 + OFF_B));
        t.we = 1'b1;
        t.addr = ADDR_W'(a);
        for (int i = 0; i < WORDS; i++) begin
            t.wd[i*DATA_W +: DATA_W] = m_data[s][w][i];
            mem_m[a/4 + i] = m_data[s][w][i];
        end
        exp_q.push_back(t);
        m_d[s][w] = 1'b0;
    endfunction

    function automatic void model_access(input logic we, input int addr, input logic [DATA_W-1:0] wd,
                                         output bit hit, output logic [DATA_W-1:0] rd);
        int   wo, s, tg, way, ra;
        txn_t t;
        wo = (addr / 4) % WORDS;
        s  = (addr / (4 * WORDS)) % SETS;
        tg = addr / (4 * WORDS * SETS);
        way = -1;
        for (int w = 0; w < WAYS; w++) if (m_v[s][w] && m_tag[s][w] == tg) way = w;
        hit = (way >= 0);
        if (!hit) begin
            for (int w = WAYS - 1; w >= 0; w--) if (!m_v[s][w]) way = w;
            if (way < 0) begin
                way = 0;
                for (int w = 1; w < WAYS; w++) if (m_used[s][w] < m_used[s][way]) way = w;
            end
            if (m_v[s][way] && m_d[s][way]) model_writeback(s, way);
            ra = (tg << (2 + OFF_B + IDX_B)) + (s << (2 + OFF_B));
            t.we = 1'b0;
            t.addr = ADDR_W'(ra);
            t.wd = '0;
            exp_q.push_back(t);
            for (int i = 0; i < WORDS; i++) m_data[s][way][i] = mem_m[ra/4 + i];
            m_v[s][way] = 1'b1;
            m_d[s][way] = 1'b0;
            m_tag[s][way] = tg;
        end
        now_t++;
        m_used[s][way] = now_t;
        if (we) begin
            m_data[s][way][wo] = wd;
            m_d[s][way] = 1'b1;
            rd = '0;
        end else begin
            rd = m_data[s][way][wo];
        end
    endfunction

    // ---------------- memory responder / cycle loop ----------------
    task automatic service(input bit is_flush, output int cyc, output int extra);
        bit   in_txn, done;
        int   wait_cnt;
        txn_t cur;
        in_txn = 1'b0; done = 1'b0; wait_cnt = 0; cyc = 0; extra = 0;
        cur.we = 1'b0; cur.addr = '0; cur.wd = '0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            cpu_req_valid = 1'b0;
            flush_req = 1'b0;
            if (mem_ack) begin
                mem_ack = 1'b0;
                in_txn = 1'b0;
            end
            if (mem_req && !in_txn) begin
                check_eq("txn_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) cur = exp_q.pop_front();
                in_txn = 1'b1;
                wait_cnt = $urandom_range(0, 5);
                extra += 1 + wait_cnt;
            end else if (in_txn) begin
                check_eq("mem_req_held", mem_req, 1'b1);
            end
            if (in_txn) begin
                check_eq("mem_we", mem_we, cur.we);
                check_eq("mem_addr", mem_addr, cur.addr);
                if (cur.we) check_eq("mem_wdata", mem_wdata, cur.wd);
                if (wait_cnt == 0) begin
                    mem_rdata = mem_blk(int'(cur.addr));
                    mem_ack = 1'b1;
                end else begin
                    wait_cnt--;
                end
            end
            done = is_flush ? flush_done : cpu_resp_valid;
        end
        if (!done) check_eq("timeout", 1'b0, 1'b1);
    endtask

    task automatic access(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
        bit                hit;
        logic [DATA_W-1:0] erd;
        int                cyc, extra;
        model_access(we, int'(addr), wd, hit, erd);
        check_eq("req_ready", cpu_req_ready, 1'b1);
        cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wd;
        @(posedge clk);
        service(1'b0, cyc, extra);
        check_eq("resp_hit", cpu_resp_hit, hit);
        check_eq("resp_rdata", cpu_resp_rdata, erd);
        check_eq("resp_latency", cyc, 2 + (hit ? 0 : 1) + extra);
        check_eq("txns_done", exp_q.size(), 0);
        check_eq("mem_req_at_resp", mem_req, 1'b0);
        @(negedge clk);
        check_eq("resp_pulse", cpu_resp_valid, 1'b0);
        exp_q.delete();
    endtask

    task automatic do_flush(input bit with_req);
        int cyc, extra, lines;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (m_v[s][w] && m_d[s][w]) model_writeback(s, w);
        flush_req = 1'b1;
        cpu_req_valid = with_req; cpu_req_we = 1'b1; cpu_req_addr = ADDR_W'($urandom);
        #1;
        check_eq("ready_in_flush", cpu_req_ready, 1'b0);
        @(posedge clk);
        service(1'b1, cyc, extra);
        lines = SETS * WAYS;
        check_eq("flush_latency", cyc, lines + extra + 1);
        check_eq("flush_txns_done", exp_q.size(), 0);
        @(negedge clk);
        check_eq("flush_done_pulse", flush_done, 1'b0);
        check_eq("ready_after_flush", cpu_req_ready, 1'b1);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cpu_req_valid = 1'b0; flush_req = 1'b0; mem_ack = 1'b0;
        #1;
        check_eq("rst_ready", cpu_req_ready, 1'b1);
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_mem_we", mem_we, 1'b0);
        check_eq("rst_mem_addr", mem_addr, '0);
        check_eq("rst_resp_valid", cpu_resp_valid, 1'b0);
        check_eq("rst_resp_rdata", cpu_resp_rdata, '0);
        check_eq("rst_flush_done", flush_done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bit found;
        for (int i = 0; i < MEM_WORDS; i++) mem_m[i] = $urandom;
        cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
        flush_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        #2;
        do_reset();

        // Directed walk through refill, hit, LRU victim and dirty eviction.
        access(1'b0, 10'h000, 32'h0);
        access(1'b1, 10'h000, 32'h000000FF);
        access(1'b0, 10'h000, 32'h0);
        access(1'b0, 10'h200, 32'h0);
        access(1'b0, 10'h000, 32'h0);
        access(1'b0, 10'h300, 32'h0);
        access(1'b0, 10'h200, 32'h0);
        access(1'b1, 10'h208, 32'hA5A5_0001);
        access(1'b1, 10'h014, 32'h5A5A_0002);
        do_flush(1'b1);
        do_flush(1'b0);

        // Reset while a refill is outstanding: the line must not be installed.
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 10'h100;
        @(posedge clk);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            cpu_req_valid = 1'b0;
            found = mem_req && !mem_we;
        end
        check_eq("abort_refill_seen", found, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_mem_req", mem_req, 1'b0);
        check_eq("abort_ready", cpu_req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        access(1'b0, 10'h100, 32'h0);
        access(1'b0, 10'h000, 32'h0);

        // Random traffic on a small tag pool to force conflicts and evictions.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_flush(1'($urandom_range(0, 1)));
            end else begin
                access(1'($urandom_range(0, 1)),
                       ADDR_W'(($urandom_range(0, 3) << 5) | $urandom_range(0, 31)),
                       DATA_W'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
